psum_deskew_collector: RTL and testbench

- Sits below the bottom row of the weight-stationary MAC systolic array and consumes the skewed partial sums leaving each column.
- Column j output is delayed by j cycles relative to column 0. The block re-aligns the columns into complete result rows and buffers them in a small FIFO.
- Rows are handed to the writeback side over a valid/ready handshake, so the free-running array never has to stall.

---
 rtl/systolic_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/psum_deskew_collector.sv | 199 +++++++++++++++++++
 tb/tb_psum_deskew_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the systolic array periphery
//
// Purpose:
//   Holds the items shared by the blocks around the MAC array:
//   - the psum width, derived from the operand width;
//   - the collector FSM state encoding;
//   - a lane-offset helper for N lanes packed into one flat bus.
// Ports: none (package).

package systolic_pkg;

  // A psum carries the product width (2*bw) plus accumulation headroom (bw).
  localparam int PSUM_MULT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  function automatic int psum_width(input int bw);
    return PSUM_MULT * bw;
  endfunction

  // LSB position of a lane in a packed bus. Use it as bus[lane_lsb(j, pw) +: pw].
  function automatic int lane_lsb(input int lane, input int pw);
    return lane * pw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with simultaneous push/pop
//
// Purpose:
//   Single-clock FIFO. The head entry is visible on head_o while the FIFO is
//   not empty. A push to a full FIFO is accepted when a pop happens in the
//   same cycle, because the pop frees the slot. A push to a full FIFO with no
//   pop is not accepted. The caller is responsible for flagging that drop.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-low reset
//   push_i       in   write push_data_i this cycle
//   push_data_i  in   WIDTH-bit entry to write
//   pop_i        in   consume the head entry (ignored when empty)
//   head_o       out  current head entry (holds its last value when empty)
//   empty_o      out  FIFO holds no entries
//   full_o       out  FIFO holds DEPTH entries

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Each pointer has one extra wrap bit, so full and empty can be told apart.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      // Storage is cleared too, so the head reads as zero after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign head_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/psum_deskew_collector.sv
// rtl/psum_deskew_collector.sv - re-aligns skewed column psums into buffered result rows
//
// Purpose:
//   Sits below the bottom row of the systolic array. Column j arrives j
//   cycles after column 0. Each column is delayed by N-1-j register stages, so
//   a full row lines up at the deskew output. After each start, a counter FSM
//   picks M aligned rows out of the free-running stream and pushes each one
//   into a show-ahead FIFO. The writeback side drains the FIFO over
//   valid/ready.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   start      in   one-cycle pulse, sampled only in IDLE
//   psum_in    in   N*PW bottom-row psums, column j at [j*PW +: PW]
//   out_data   out  aligned row at the FIFO head, same lane packing
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer accepts the head row
//   out_last   out  head row is row M-1 of its tile
//   busy       out  FSM not in IDLE
//   overflow   out  sticky: a row was dropped because the FIFO was full

module psum_deskew_collector
  import systolic_pkg::*;
#(
  parameter int bit_width  = 8,
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int PIPE_LAT   = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [N*psum_width(bit_width)-1:0] psum_in,
  output logic [N*psum_width(bit_width)-1:0] out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               overflow
);

  localparam int PW       = psum_width(bit_width);
  localparam int DW       = N * PW;
  // Row 0 of the tile is aligned at the deskew output on this cycle count after start.
  localparam int FILL_END = PIPE_LAT + N - 1;
  localparam int CW       = $clog2(FILL_END + 1);
  localparam int RW       = (M > 1) ? $clog2(M) : 1;

  // ---------------------------------------------------------------------------
  // Deskew: column j gets N-1-j delay stages and the last column passes
  // straight through. The chains shift every cycle, whatever the FSM state,
  // so the alignment never depends on when start arrived.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] aligned;

  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int STAGES = N - 1 - j;
    if (STAGES == 0) begin : g_pass
      assign aligned[lane_lsb(j, PW) +: PW] = psum_in[lane_lsb(j, PW) +: PW];
    end else begin : g_dly
      logic [PW-1:0] sr_q [STAGES];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int k = 0; k < STAGES; k++) sr_q[k] <= '0;
        end else begin
          sr_q[0] <= psum_in[lane_lsb(j, PW) +: PW];
          for (int k = 1; k < STAGES; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign aligned[lane_lsb(j, PW) +: PW] = sr_q[STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] ridx_q, ridx_d;
  logic          push;
  logic          push_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ridx_q  <= ridx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ridx_d  = ridx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          cnt_d   = CW'(1);
        end
      end
      FILL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FILL_END)) begin
          // Row 0 is written on this edge, so a single-row tile is already finished.
          cnt_d = '0;
          if (M == 1) begin
            state_d = IDLE;
            ridx_d  = '0;
          end else begin
            state_d = CAPTURE;
            ridx_d  = RW'(1);
          end
        end
      end
      CAPTURE: begin
        ridx_d = ridx_q + RW'(1);
        if (ridx_q == RW'(M - 1)) begin
          state_d = IDLE;
          ridx_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ridx_d  = '0;
      end
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    case (state_q)
      FILL: begin
        if (cnt_q == CW'(FILL_END)) begin
          push      = 1'b1;
          push_last = (M == 1);
        end
      end
      CAPTURE: begin
        push      = 1'b1;
        push_last = (ridx_q == RW'(M - 1));
      end
      default: begin
        push      = 1'b0;
        push_last = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Row FIFO and overflow flag
  // ---------------------------------------------------------------------------
  logic [DW:0] fifo_head;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        drop;
  logic        overflow_q, overflow_d;

  sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({push_last, aligned}),
    .pop_i       (out_ready),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DW-1:0];
  assign out_last  = fifo_head[DW];
  assign pop       = out_valid && out_ready;

  // A pop in the same cycle frees a slot, so only a push with no pop against a full FIFO loses a row.
  assign drop       = push && fifo_full && !pop;
  assign overflow_d = overflow_q || drop;

  always_ff @(posedge clk) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// tb/tb_psum_deskew_collector.sv - directed self-checking bench for psum_deskew_collector

module tb_psum_deskew_collector;

  localparam int N  = 4;
  localparam int PW = 24;
  localparam int BW = N * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] psum_in = '0;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int failures = 0;
  // Start edge of the second tile, relative to the first one. A negative value means no second tile.
  int b2 = -1;

  psum_deskew_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .psum_in   (psum_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Expected aligned row: lane j = tile*0x100 + 0x10*r + j.
  function automatic logic [BW-1:0] row_val(input int tile, input int r);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*PW +: PW] = PW'(tile * 256 + 16 * r + j);
    return v;
  endfunction

  // Value on psum_in just before edge k. Lanes outside a row window carry junk.
  function automatic logic [BW-1:0] drive(input int k);
    logic [BW-1:0] v;
    int r;
    v = '0;
    for (int j = 0; j < N; j++) begin
      v[j*PW +: PW] = PW'(32'hE00000 + k * 16 + j);
      r = k - 5 - j;
      if (r >= 0 && r < 4) v[j*PW +: PW] = PW'(16 * r + j);
      if (b2 >= 0) begin
        r = k - b2 - 5 - j;
        if (r >= 0 && r < 4) v[j*PW +: PW] = PW'(256 + 16 * r + j);
      end
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int k, input logic st, input logic rdy);
    start     = st;
    out_ready = rdy;
    psum_in   = drive(k);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; psum_in = '1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got v=%b l=%b b=%b o=%b exp all 0", out_valid, out_last, busy, overflow);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", out_data);
    end
    rst = 1'b1;
    step();
  endtask

  // A single tile drained with out_ready=1 throughout. A second start at edge
  // extra_start (when it is >= 0) must be ignored.
  task automatic run_clean_tile(input string name, input int extra_start);
    logic ev, eb, el;
    b2 = -1;
    for (int k = 0; k <= 20; k++) begin
      cyc(k, (k == 0) || (k == extra_start), 1'b1);
      ev = (k >= 8 && k <= 11);
      eb = (k <= 10);
      el = (k == 11);
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("FAIL %s_valid k=%0d got=%b exp=%b", name, k, out_valid, ev);
      end
      checks++;
      if (busy !== eb) begin
        failures++;
        $display("FAIL %s_busy k=%0d got=%b exp=%b", name, k, busy, eb);
      end
      if (ev) begin
        checks++;
        if (out_data !== row_val(0, k - 8) || out_last !== el) begin
          failures++;
          $display("FAIL %s_row k=%0d got=%h/%b exp=%h/%b", name, k, out_data, out_last, row_val(0, k - 8), el);
        end
      end
      checks++;
      if (overflow !== 1'b0) begin
        failures++;
        $display("FAIL %s_ovf k=%0d got=%b exp=0", name, k, overflow);
      end
    end
  endtask

  task automatic test_basic();
    run_clean_tile("basic", -1);
  endtask

  task automatic test_start_while_busy();
    run_clean_tile("busy_start", 3);
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] ed;
    b2 = -1;
    for (int k = 0; k <= 24; k++) begin
      cyc(k, k == 0, k >= 20);
      ed = (k >= 20) ? row_val(0, k - 19) : row_val(0, 0);
      checks++;
      if (out_valid !== (k >= 8 && k <= 22)) begin
        failures++;
        $display("FAIL bp_valid k=%0d got=%b", k, out_valid);
      end
      if (k >= 8 && k <= 22) begin
        checks++;
        if (out_data !== ed || out_last !== (k == 22)) begin
          failures++;
          $display("FAIL bp_row k=%0d got=%h/%b exp=%h/%b", k, out_data, out_last, ed, k == 22);
        end
      end
      checks++;
      if (overflow !== 1'b0) begin
        failures++;
        $display("FAIL bp_ovf k=%0d got=%b exp=0", k, overflow);
      end
    end
  endtask

  task automatic test_full_pop();
    logic [BW-1:0] ed;
    b2 = 12;
    for (int k = 0; k <= 30; k++) begin
      cyc(k, (k == 0) || (k == 12), k >= 20);
      if (k <= 19)      ed = row_val(0, 0);
      else if (k <= 22) ed = row_val(0, k - 19);
      else              ed = row_val(1, k - 23);
      checks++;
      if (out_valid !== (k >= 8 && k <= 26)) begin
        failures++;
        $display("FAIL fp_valid k=%0d got=%b", k, out_valid);
      end
      if (k >= 8 && k <= 26) begin
        checks++;
        if (out_data !== ed || out_last !== (k == 22 || k == 26)) begin
          failures++;
          $display("FAIL fp_row k=%0d got=%h/%b exp=%h/%b", k, out_data, out_last, ed, (k == 22 || k == 26));
        end
      end
      checks++;
      if (overflow !== 1'b0) begin
        failures++;
        $display("FAIL fp_ovf k=%0d got=%b exp=0", k, overflow);
      end
    end
    b2 = -1;
  endtask

  task automatic test_overflow();
    logic [BW-1:0] ed;
    logic eb;
    b2 = 12;
    for (int k = 0; k <= 31; k++) begin
      cyc(k, (k == 0) || (k == 12), k >= 24);
      ed = (k >= 24) ? row_val(0, k - 23) : row_val(0, 0);
      eb = (k <= 10) || (k >= 12 && k <= 22);
      checks++;
      if (overflow !== (k >= 20)) begin
        failures++;
        $display("FAIL ovf_flag k=%0d got=%b exp=%b", k, overflow, k >= 20);
      end
      checks++;
      if (busy !== eb) begin
        failures++;
        $display("FAIL ovf_busy k=%0d got=%b exp=%b", k, busy, eb);
      end
      checks++;
      if (out_valid !== (k >= 8 && k <= 26)) begin
        failures++;
        $display("FAIL ovf_valid k=%0d got=%b", k, out_valid);
      end
      if (k >= 8 && k <= 26) begin
        checks++;
        if (out_data !== ed || out_last !== (k == 26)) begin
          failures++;
          $display("FAIL ovf_row k=%0d got=%h/%b exp=%h/%b", k, out_data, out_last, ed, k == 26);
        end
      end
    end
    b2 = -1;
  endtask

  task automatic test_reset_mid();
    b2 = -1;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) rst = 1'b0;
      cyc(k, k == 0, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_flags got v=%b b=%b o=%b exp 0", out_valid, busy, overflow);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL rstmid_data got=%h exp=0", out_data);
    end
    rst = 1'b1;
    cyc(11, 1'b0, 1'b0);
    run_clean_tile("after_rst", -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_full_pop();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
